// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Takes a DATA_W-bit word over valid/ready and sends one frame on tx_out:
// a low start bit, the data LSB first, then a high stop bit. Each bit is
// held for CLKS_PER_BIT clocks. Every output comes straight from a flop.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t              r_state,    w_state_nxt;
    logic [DATA_W-1:0]   r_shift,    w_shift_nxt;
    logic [BIT_W-1:0]    r_bit_cnt,  w_bit_cnt_nxt;
    logic [BAUD_W-1:0]   r_baud_cnt, w_baud_cnt_nxt;
    logic                r_tx_out,   w_tx_out_nxt;
    logic                r_tx_ready, w_tx_ready_nxt;
    logic                r_busy,     w_busy_nxt;

    logic                w_accept;
    logic                w_wrap;
    logic [DATA_W-1:0]   w_shift_dn;

    // A word is taken only when ready was already advertised by the flop.
    assign w_accept   = r_tx_ready & tx_valid;
    // Last clock of the current bit period.
    assign w_wrap     = (r_baud_cnt == BAUD_LAST);
    assign w_shift_dn = r_shift >> 1;

    assign tx_ready = r_tx_ready;
    assign tx_out   = r_tx_out;
    assign busy     = r_busy;

    // State and datapath registers; reset drops the line to idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_tx_out   <= 1'b1;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_tx_out   <= w_tx_out_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic; bits advance only on baud wrap.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_baud_cnt_nxt = w_wrap ? '0 : r_baud_cnt + BAUD_W'(1);
        w_tx_out_nxt   = r_tx_out;
        w_tx_ready_nxt = r_tx_ready;
        w_busy_nxt     = r_busy;

        case (r_state)
            S_IDLE: begin
                w_baud_cnt_nxt = '0;
                w_tx_out_nxt   = 1'b1;
                w_tx_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
                if (w_accept) begin
                    w_shift_nxt    = tx_data;
                    w_tx_ready_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_tx_out_nxt   = 1'b0;
                    w_state_nxt    = S_START;
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_tx_out_nxt  = r_shift[0];
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_shift_nxt = w_shift_dn;
                    if (r_bit_cnt == BIT_LAST) begin
                        // Counter is not stepped past its range on the last bit.
                        w_tx_out_nxt = 1'b1;
                        w_state_nxt  = S_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                        w_tx_out_nxt  = w_shift_dn[0];
                    end
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    w_tx_out_nxt   = 1'b1;
                    w_tx_ready_nxt = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
